cache_control_nway: RTL
=======================

# cache_control_nway

Parametrised write-back, write-allocate control FSM for an N-way set-associative cache. It generalises the fixed 2-way controller to WAYS ways. Victims are chosen first-invalid, then tree pseudo-LRU. The victim way is registered for the whole miss sequence. The block sits between the CPU-side request interface and the cache datapath / physical-memory port. The datapath holds the tag, valid, dirty, data and PLRU arrays; this block only issues their control signals.

## Interface
- WAYS, 4: number of ways; power of two, 2..8
- LINE_BYTES, 32: bytes per line; width of the byte-enable mask
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mem_read, mem_write  in  1 each  CPU request; held until mem_resp
- mem_byte_enable  in  LINE_BYTES  CPU write byte mask
- mem_resp  out  1  one-cycle request completion
- pmem_read, pmem_write  out  1 each  physical-memory request
- pmem_resp  in  1  one-cycle memory completion
- hit_vec, valid_vec, dirty_vec  in  WAYS each  per-way status of the addressed set (valid in COMPARE)
- plru_in  in  WAYS-1  PLRU tree bits of the addressed set
- plru_out  out  WAYS-1  updated PLRU bits
- load_plru  out  1  write plru_out
- read_arrays  out  1  array read strobe
- way_sel  out  WAYS  one-hot way for data mux, writes and address mux
- data_we  out  LINE_BYTES  byte write mask applied to the way_sel way
- load_tag, load_valid, load_dirty  out  WAYS each  per-way array writes
- dirty_in, valid_in  out  1 each  value written by load_dirty / load_valid
- data_in_sel  out  data_in_sel_t  CPU_IN or PMEM_IN
- addr_sel  out  addr_sel_t  CPU_ADDR or VICTIM_ADDR

## Operation
- States: IDLE, COMPARE, WRITEBACK, FILL.
- IDLE
  - read_arrays=1.
  - On mem_read|mem_write go to COMPARE; otherwise stay.
- COMPARE, hit (|hit_vec)
  - way_sel=hit_vec, mem_resp=1, load_plru=1.
  - plru_out is plru_in with the path pointing away from the hit way.
  - On a write hit also: data_we=mem_byte_enable, data_in_sel=CPU_IN, load_dirty[hit]=1, dirty_in=1.
  - Next state IDLE.
- COMPARE, miss
  - victim = lowest-index way with valid_vec=0; if all valid, the PLRU victim decoded from plru_in.
  - The victim is registered into victim_q at the clock edge.
  - Next state WRITEBACK if the victim is valid&dirty, else FILL.
- WRITEBACK
  - way_sel=victim_q, addr_sel=VICTIM_ADDR, pmem_write=1.
  - On pmem_resp go to FILL.
- FILL
  - way_sel=victim_q, addr_sel=CPU_ADDR, data_in_sel=PMEM_IN, pmem_read=1.
  - On pmem_resp: data_we=all ones; load_tag, load_valid and load_dirty set for victim_q; valid_in=1, dirty_in=0. Next state IDLE.
  - The request is then replayed and hits.
- hit_vec with more than one bit set is illegal; the bench flags it as an assertion failure.
- mem_read and mem_write asserted together is illegal; write takes priority.
- PLRU is updated only on hits. The replayed access after a fill updates it.

## Timing
- Reset (rst_n low, any state, including mid-WRITEBACK or mid-FILL):
  - state=IDLE, victim_q=0.
  - All outputs 0, except data_in_sel=CPU_IN and addr_sel=CPU_ADDR.
  - Outputs are combinational from state, so they fall immediately on reset assertion.
- Hit latency: 2 cycles from the request in IDLE; mem_resp in the second cycle.
- Clean miss: IDLE, COMPARE, FILL (k cycles), IDLE, COMPARE. mem_resp 4+k cycles after the request, where k = cycles in FILL up to and including pmem_resp.
- Dirty miss additionally spends WRITEBACK cycles.
- pmem_read and pmem_write stay high through the pmem_resp cycle and are low the next cycle. They are never high together.
- pmem_resp seen in IDLE or COMPARE is ignored.
- victim_q is stable from the COMPARE exit edge until FILL exits.

## Configuration
- CACHE_PERF_CNT_EN defined:
  - Adds input perf_clr.
  - Adds outputs hit_cnt, miss_cnt and wb_cnt, 32 bits each.
  - Increment events: each COMPARE hit, each COMPARE miss, each WRITEBACK entry respectively.
  - Counters saturate at 32'hFFFF_FFFF. rst_n or perf_clr zeroes them; perf_clr wins over a same-cycle increment.
- CACHE_PERF_CNT_EN undefined: ports and logic absent; behaviour otherwise identical.

## Structure
- Package cache_nway_pkg:
  - state_t
  - data_in_sel_t {CPU_IN, PMEM_IN}
  - addr_sel_t {CPU_ADDR, VICTIM_ADDR}
  - functions clog2-based WAY_IDX_W and onehot-to-index
- Sub-module plru_tree #(WAYS), purely combinational:
  - inputs plru_in and hit_idx
  - outputs plru_victim_idx and plru_updated
- The FSM, victim logic and counters stay in cache_control_nway.

## Test plan
- WAYS=4, plru_in=3'b000, read with hit_vec=4'b0100 → mem_resp in cycle 2, load_plru=1, plru_out points away from way 2, no pmem activity.
- Write hit, hit_vec=4'b0001, mem_byte_enable=32'h0000_00F0 → data_we=32'h0000_00F0, way_sel=4'b0001, load_dirty=4'b0001, dirty_in=1.
- Miss with valid_vec=4'b1011 → victim way 2, no WRITEBACK, pmem_read held 3 cycles until pmem_resp, then load_valid=4'b0100 and data_we=all ones; replay hit mem_resp.
- Miss with all ways valid, dirty_vec=4'b1111, plru_in selecting way 3 → WRITEBACK with way_sel=4'b1000 and addr_sel=VICTIM_ADDR, then FILL into way 3; pmem_read/pmem_write never overlap.
- rst_n low during FILL with pmem_read high → pmem_read falls immediately, state IDLE; after release, a held request restarts from COMPARE.
- With CACHE_PERF_CNT_EN: 5 hits, 2 misses, 1 writeback → counters 5/2/1; perf_clr together with a hit → all 0; hit_cnt preloaded at max stays saturated.

Source files
------------

// File: rtl/cache_nway_pkg.sv
// Shared types and helpers for the N-way cache controller.
package cache_nway_pkg;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;
    typedef enum logic {CPU_IN, PMEM_IN} data_in_sel_t;
    typedef enum logic {CPU_ADDR, VICTIM_ADDR} addr_sel_t;

    localparam int unsigned MAX_WAYS  = 8;
    localparam int unsigned MAX_IDX_W = 3;

    // Width of a way index; at least one bit so a 1-bit index exists for 2 ways.
    function automatic int unsigned way_idx_w(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_WAYS-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            if (oh[i]) idx = idx | MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cache_control_nway_if.sv
// CPU request, array control and physical-memory signals of the cache controller.
// Counter signals exist only when CACHE_PERF_CNT_EN is defined.
interface cache_control_nway_if
    import cache_nway_pkg::*;
#(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned LINE_BYTES = 32
);
    logic                  mem_read;
    logic                  mem_write;
    logic [LINE_BYTES-1:0] mem_byte_enable;
    logic                  mem_resp;
    logic                  pmem_read;
    logic                  pmem_write;
    logic                  pmem_resp;
    logic [WAYS-1:0]       hit_vec;
    logic [WAYS-1:0]       valid_vec;
    logic [WAYS-1:0]       dirty_vec;
    logic [WAYS-2:0]       plru_in;
    logic [WAYS-2:0]       plru_out;
    logic                  load_plru;
    logic                  read_arrays;
    logic [WAYS-1:0]       way_sel;
    logic [LINE_BYTES-1:0] data_we;
    logic [WAYS-1:0]       load_tag;
    logic [WAYS-1:0]       load_valid;
    logic [WAYS-1:0]       load_dirty;
    logic                  dirty_in;
    logic                  valid_in;
    data_in_sel_t          data_in_sel;
    addr_sel_t             addr_sel;
`ifdef CACHE_PERF_CNT_EN
    logic                  perf_clr;
    logic [31:0]           hit_cnt;
    logic [31:0]           miss_cnt;
    logic [31:0]           wb_cnt;
`endif

    // Controller side.
    modport slave (
        input  mem_read, mem_write, mem_byte_enable, pmem_resp,
               hit_vec, valid_vec, dirty_vec, plru_in,
        output mem_resp, pmem_read, pmem_write, plru_out, load_plru, read_arrays,
               way_sel, data_we, load_tag, load_valid, load_dirty, dirty_in, valid_in,
               data_in_sel, addr_sel
`ifdef CACHE_PERF_CNT_EN
        , input perf_clr, output hit_cnt, miss_cnt, wb_cnt
`endif
    );

    // CPU / datapath / memory side.
    modport master (
        output mem_read, mem_write, mem_byte_enable, pmem_resp,
               hit_vec, valid_vec, dirty_vec, plru_in,
        input  mem_resp, pmem_read, pmem_write, plru_out, load_plru, read_arrays,
               way_sel, data_we, load_tag, load_valid, load_dirty, dirty_in, valid_in,
               data_in_sel, addr_sel
`ifdef CACHE_PERF_CNT_EN
        , output perf_clr, input hit_cnt, miss_cnt, wb_cnt
`endif
    );

endinterface

// File: rtl/cache_control_nway_plru_tree.sv
// Tree pseudo-LRU: victim decode and hit update. Node 0 is the root, children of n
// are 2n+1 / 2n+2; a bit of 1 steers the victim toward the upper-index half.
module plru_tree
    import cache_nway_pkg::*;
#(
    parameter int unsigned WAYS = 4
) (
    input  logic [WAYS-2:0]              plru_in,
    input  logic [way_idx_w(WAYS)-1:0]   hit_idx,
    output logic [way_idx_w(WAYS)-1:0]   plru_victim_idx,
    output logic [WAYS-2:0]              plru_updated
);
    localparam int unsigned IDX_W  = way_idx_w(WAYS);
    localparam int unsigned LEVELS = $clog2(WAYS);

    logic [IDX_W-1:0] vnode;
    logic [IDX_W-1:0] unode;

    // Follow the tree bits from the root; each bit taken is one index bit, MSB first.
    always_comb begin
        plru_victim_idx = '0;
        vnode           = '0;
        for (int l = 0; l < LEVELS; l++) begin
            plru_victim_idx[LEVELS-1-l] = plru_in[vnode];
            vnode = IDX_W'({vnode, 1'b1}) + IDX_W'(plru_in[vnode]);
        end
    end

    // Walk the hit way's path and point every node on it at the other subtree.
    always_comb begin
        plru_updated = plru_in;
        unode        = '0;
        for (int l = 0; l < LEVELS; l++) begin
            plru_updated[unode] = ~hit_idx[LEVELS-1-l];
            unode = IDX_W'({unode, 1'b1}) + IDX_W'(hit_idx[LEVELS-1-l]);
        end
    end

endmodule

// File: rtl/cache_control_nway.sv
// Write-back, write-allocate control FSM for an N-way set-associative cache.
// Optional hit/miss/writeback counters are built when CACHE_PERF_CNT_EN is defined.
module cache_control_nway
    import cache_nway_pkg::*;
#(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned LINE_BYTES = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_control_nway_if.slave  bus
);
    localparam int unsigned WAY_IDX_W = way_idx_w(WAYS);

    state_t               state;
    state_t               state_nxt;
    logic [WAY_IDX_W-1:0] victim_q;
    logic [WAY_IDX_W-1:0] victim_idx;
    logic [WAY_IDX_W-1:0] first_inv_idx;
    logic [WAY_IDX_W-1:0] hit_idx;
    logic [WAY_IDX_W-1:0] plru_victim_idx;
    logic [WAYS-2:0]      plru_updated;
    logic [WAYS-1:0]      victim_oh;
    logic                 hit;
    logic                 victim_dirty;

    assign hit       = |bus.hit_vec;
    assign hit_idx   = WAY_IDX_W'(onehot_to_idx(MAX_WAYS'(bus.hit_vec)));
    assign victim_oh = WAYS'(1) << victim_q;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .plru_in         (bus.plru_in),
        .hit_idx         (hit_idx),
        .plru_victim_idx (plru_victim_idx),
        .plru_updated    (plru_updated)
    );

    // Lowest-index invalid way wins; PLRU only decides when the set is full.
    always_comb begin
        first_inv_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!bus.valid_vec[i]) first_inv_idx = WAY_IDX_W'(i);
        end
        victim_idx   = (&bus.valid_vec) ? plru_victim_idx : first_inv_idx;
        victim_dirty = bus.valid_vec[victim_idx] & bus.dirty_vec[victim_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            victim_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == COMPARE && !hit) victim_q <= victim_idx;
        end
    end

    // Outputs decode from state; gating with rst_n drops them the moment reset asserts.
    always_comb begin
        state_nxt           = state;
        bus.mem_resp        = 1'b0;
        bus.pmem_read       = 1'b0;
        bus.pmem_write      = 1'b0;
        bus.plru_out        = '0;
        bus.load_plru       = 1'b0;
        bus.read_arrays     = 1'b0;
        bus.way_sel         = '0;
        bus.data_we         = '0;
        bus.load_tag        = '0;
        bus.load_valid      = '0;
        bus.load_dirty      = '0;
        bus.dirty_in        = 1'b0;
        bus.valid_in        = 1'b0;
        bus.data_in_sel     = CPU_IN;
        bus.addr_sel        = CPU_ADDR;
        if (rst_n) begin
            unique case (state)
                IDLE: begin
                    bus.read_arrays = 1'b1;
                    if (bus.mem_read || bus.mem_write) state_nxt = COMPARE;
                end
                COMPARE: begin
                    if (hit) begin
                        bus.way_sel   = bus.hit_vec;
                        bus.mem_resp  = 1'b1;
                        bus.load_plru = 1'b1;
                        bus.plru_out  = plru_updated;
                        if (bus.mem_write) begin
                            bus.data_we    = bus.mem_byte_enable;
                            bus.load_dirty = bus.hit_vec;
                            bus.dirty_in   = 1'b1;
                        end
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = victim_dirty ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    bus.way_sel    = victim_oh;
                    bus.addr_sel   = VICTIM_ADDR;
                    bus.pmem_write = 1'b1;
                    if (bus.pmem_resp) state_nxt = FILL;
                end
                FILL: begin
                    bus.way_sel     = victim_oh;
                    bus.data_in_sel = PMEM_IN;
                    bus.pmem_read   = 1'b1;
                    if (bus.pmem_resp) begin
                        bus.data_we    = '1;
                        bus.load_tag   = victim_oh;
                        bus.load_valid = victim_oh;
                        bus.load_dirty = victim_oh;
                        bus.valid_in   = 1'b1;
                        state_nxt      = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef CACHE_PERF_CNT_EN
    localparam int unsigned CNT_W = 32;

    logic hit_evt;
    logic miss_evt;
    logic wb_evt;

    assign hit_evt  = (state == COMPARE) && hit;
    assign miss_evt = (state == COMPARE) && !hit;
    assign wb_evt   = miss_evt && victim_dirty;

    // Saturating event counters; a clear overrides any same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.hit_cnt  <= '0;
            bus.miss_cnt <= '0;
            bus.wb_cnt   <= '0;
        end else if (bus.perf_clr) begin
            bus.hit_cnt  <= '0;
            bus.miss_cnt <= '0;
            bus.wb_cnt   <= '0;
        end else begin
            if (hit_evt && bus.hit_cnt != '1)   bus.hit_cnt  <= bus.hit_cnt + CNT_W'(1);
            if (miss_evt && bus.miss_cnt != '1) bus.miss_cnt <= bus.miss_cnt + CNT_W'(1);
            if (wb_evt && bus.wb_cnt != '1)     bus.wb_cnt   <= bus.wb_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
